// File: rtl/tt_load_data_queue_pkg.sv
// Shared definitions for the vector load-data queue: default widths and sync FSM encoding.
package tt_load_data_queue_pkg;
  localparam int LQ_DEPTH   = 8;
  localparam int LQ_DATA_W  = 512;
  localparam int LQ_SEQID_W = 34;

  typedef enum logic [1:0] {
    LQ_IDLE     = 2'b00,
    LQ_WAIT_END = 2'b01,
    LQ_DONE     = 2'b10
  } lq_sync_state_t;
endpackage

// File: rtl/tt_load_data_queue_if.sv
// Load-beat, writeback and memop-sync signals between core, queue and memop FSM.
interface tt_load_data_queue_if
  import tt_load_data_queue_pkg::*;
#(
  parameter int DEPTH   = LQ_DEPTH,
  parameter int DATA_W  = LQ_DATA_W,
  parameter int SEQID_W = LQ_SEQID_W
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               i_load_valid;
  logic [DATA_W-1:0]  i_load_data;
  logic [SEQID_W-1:0] i_load_seq_id;
  logic               o_load_credit;
  logic               o_wb_valid;
  logic [DATA_W-1:0]  o_wb_data;
  logic [SEQID_W-1:0] o_wb_seq_id;
  logic               i_wb_ready;
  logic               i_memop_sync_start;
  logic               i_ovi_sync_end;
  logic               o_memop_sync_end;
  logic               o_lq_empty;
  logic [CNT_W-1:0]   o_lq_count;
  logic               o_overflow;
  logic               o_sync_err;

  modport slave (
    input  i_load_valid, i_load_data, i_load_seq_id, i_wb_ready,
           i_memop_sync_start, i_ovi_sync_end,
    output o_load_credit, o_wb_valid, o_wb_data, o_wb_seq_id,
           o_memop_sync_end, o_lq_empty, o_lq_count, o_overflow, o_sync_err
  );

  modport master (
    output i_load_valid, i_load_data, i_load_seq_id, i_wb_ready,
           i_memop_sync_start, i_ovi_sync_end,
    input  o_load_credit, o_wb_valid, o_wb_data, o_wb_seq_id,
           o_memop_sync_end, o_lq_empty, o_lq_count, o_overflow, o_sync_err
  );
endinterface

// File: rtl/tt_load_data_queue_fifo.sv
// Generic synchronous FIFO with occupancy count; head is read straight from storage (no bypass).
module tt_lq_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic [W-1:0]     i_wdata,
  input  logic             i_pop,
  output logic [W-1:0]     o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_push_ok
);
  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [AW:0]             r_wptr, r_rptr;
  logic [CNT_W-1:0]        r_count;
  logic                    w_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign w_pop     = i_pop && !o_empty;
  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign o_push_ok = i_push && (!o_full || w_pop);
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];
  assign o_count   = r_count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (o_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CNT_W'(o_push_ok) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (o_push_ok) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end
endmodule

// File: rtl/tt_load_data_queue.sv
// Load-data queue: buffers core load beats for writeback, returns credits, tracks memop sync.
module tt_load_data_queue
  import tt_load_data_queue_pkg::*;
#(
  parameter int DEPTH   = LQ_DEPTH,
  parameter int DATA_W  = LQ_DATA_W,
  parameter int SEQID_W = LQ_SEQID_W
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  tt_load_data_queue_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int W     = DATA_W + SEQID_W;

  logic             w_pop, w_empty, w_full, w_push_ok;
  logic [W-1:0]     w_head;
  logic [CNT_W-1:0] w_count;
  logic             r_credit, r_overflow, r_sync_err;
  lq_sync_state_t   r_state, w_state_nxt;
  logic             w_sync_end, w_err_set;

  assign w_pop = !w_empty && bus.i_wb_ready;

  tt_lq_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (bus.i_load_valid),
    .i_wdata   ({bus.i_load_seq_id, bus.i_load_data}),
    .i_pop     (w_pop),
    .o_rdata   (w_head),
    .o_count   (w_count),
    .o_empty   (w_empty),
    .o_full    (w_full),
    .o_push_ok (w_push_ok)
  );

  assign bus.o_wb_valid       = !w_empty;
  assign bus.o_wb_data        = w_head[DATA_W-1:0];
  assign bus.o_wb_seq_id      = w_head[W-1:DATA_W];
  assign bus.o_lq_empty       = w_empty;
  assign bus.o_lq_count       = w_count;
  assign bus.o_load_credit    = r_credit;
  assign bus.o_overflow       = r_overflow;
  assign bus.o_sync_err       = r_sync_err;
  assign bus.o_memop_sync_end = w_sync_end;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_credit   <= 1'b0;
      r_overflow <= 1'b0;
      r_sync_err <= 1'b0;
      r_state    <= LQ_IDLE;
    end else begin
      r_credit <= w_pop;
      if (bus.i_load_valid && !w_push_ok) r_overflow <= 1'b1;
      if (w_err_set)                      r_sync_err <= 1'b1;
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sync_end  = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      LQ_IDLE: begin
        if (bus.i_memop_sync_start && bus.i_ovi_sync_end) w_state_nxt = LQ_DONE;
        else if (bus.i_memop_sync_start)                  w_state_nxt = LQ_WAIT_END;
        else if (bus.i_ovi_sync_end)                      w_err_set   = 1'b1;
      end
      LQ_WAIT_END: begin
        if (bus.i_ovi_sync_end) w_state_nxt = LQ_DONE;
      end
      LQ_DONE: begin
        // A start level still held here opens the next sync window.
        w_sync_end  = 1'b1;
        w_state_nxt = bus.i_memop_sync_start ? LQ_WAIT_END : LQ_IDLE;
      end
      default: w_state_nxt = LQ_IDLE;
    endcase
  end
endmodule

// File: doc/tt_load_data_queue.md
Name: tt_load_data_queue

Overview:
- Sits between the core-side vector load-data interface and the unified memop FSM.
- Buffers returning load data beats in a FIFO and drains them to vector register writeback with a valid/ready handshake; returns one credit per drained entry.
- Tracks the memop sync handshake: accepts sync_start from the FSM, waits for the core's sync_end, and reports sync_end plus queue-empty status back to the FSM.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2; also the number of load credits the core holds after reset.
- DATA_W, 512, load data beat width.
- SEQID_W, 34, load sequence-id width.
- CNT_W, $clog2(DEPTH+1), occupancy counter width; derived, not overridable.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_load_valid  in  1  core load beat valid; no ready, credit-governed
- i_load_data  in  DATA_W  load beat data
- i_load_seq_id  in  SEQID_W  load beat sequence id
- o_load_credit  out  1  one-cycle pulse per entry popped
- o_wb_valid  out  1  head entry valid to writeback
- o_wb_data  out  DATA_W  head entry data
- o_wb_seq_id  out  SEQID_W  head entry seq id
- i_wb_ready  in  1  writeback accepts head
- i_memop_sync_start  in  1  from memop FSM; level, may stay high several cycles
- i_ovi_sync_end  in  1  core sync_end pulse
- o_memop_sync_end  out  1  one-cycle pulse to memop FSM
- o_lq_empty  out  1  queue empty
- o_lq_count  out  CNT_W  occupancy
- o_overflow  out  1  sticky: push while full without a same-cycle pop
- o_sync_err  out  1  sticky: sync_end with no sync pending

Behaviour:
- Reset, asynchronous and active-low:
  - Pointers and count are 0, so o_lq_empty=1.
  - o_wb_valid, o_load_credit, o_memop_sync_end, o_overflow and o_sync_err are all 0.
  - The sync FSM is in IDLE.
  - Asserting reset mid-operation discards all entries and any pending sync. No credits are returned for discarded entries; the core re-initialises its credits on reset.
- FIFO:
  - push = i_load_valid. pop = o_wb_valid && i_wb_ready.
  - Push is accepted if count<DEPTH, or if count==DEPTH and pop occurs in the same cycle.
  - Push while full without a pop: the beat is dropped, o_overflow is set and held until reset, and count is unchanged.
  - count += push_accepted - pop.
  - Read and write pointers wrap modulo DEPTH using an extra wrap bit; full/empty is derived from count.
  - No bypass: a beat pushed in cycle N is presented on o_wb_valid in cycle N+1 at the earliest.
  - o_wb_data and o_wb_seq_id reflect the head entry and are stable while o_wb_valid && !i_wb_ready.
  - o_lq_empty = (count==0), driven from the registered count, i.e. the post-update value visible the cycle after the pop.
  - o_load_credit is registered: it pulses in cycle N+1 for a pop in cycle N. Total credits in flight never exceed DEPTH.
- Sync FSM, states IDLE, WAIT_END, DONE:
  - IDLE: on i_memop_sync_start go to WAIT_END. A start that arrives together with i_ovi_sync_end in the same cycle goes directly to DONE.
  - WAIT_END: on i_ovi_sync_end go to DONE. Further i_memop_sync_start levels are ignored.
  - DONE: o_memop_sync_end=1 for exactly this cycle. Next state is WAIT_END if i_memop_sync_start is high, otherwise IDLE.
  - Latency from i_ovi_sync_end to o_memop_sync_end is 1 cycle.
  - i_ovi_sync_end while in IDLE with no start: ignored, and o_sync_err is set (sticky).
  - Sync tracking is independent of FIFO contents. The FSM's COMMIT state waits on o_lq_empty separately.

Decomposition:
- Shared vpu package: sync state enum (lq_sync_state_t: IDLE=2'b00, WAIT_END=2'b01, DONE=2'b10) and the SEQID_W default constant.
- One sub-module: tt_lq_fifo, a generic credit-free synchronous FIFO with count, parameterised on width and depth. The top level adds credit return, overflow detection and the sync FSM.

Test Plan:
- Push 3 beats (seq 0x1,0x2,0x3) with i_wb_ready=1 -> wb order 1,2,3, first o_wb_valid one cycle after the first push, 3 credit pulses, o_lq_empty=1 after the last pop.
- i_wb_ready=0, push 8 beats -> count=8; a 9th push -> dropped and o_overflow=1; then ready=1 -> exactly 8 beats drained, seq ids intact, count=0.
- Full queue with push and pop in the same cycle -> push accepted, count stays 8, o_overflow stays 0.
- Push 20 beats with ready toggling 1010… -> in-order delivery across pointer wrap, 20 credits total, count returns to 0.
- sync_start held for 4 cycles, sync_end in cycle 5 -> o_memop_sync_end single pulse in cycle 6. A sync_end in IDLE -> o_sync_err=1 and no sync_end pulse.
- Reset asserted with count=5 and sync in WAIT_END -> all outputs take reset values immediately (async), o_lq_empty=1, FSM in IDLE, no credits emitted.
